// File: rtl/ram_arbiter.sv
// Two-port (CPU / debug) arbiter in front of a single-port 32x32 RAM.
// Each access takes IDLE -> ACCESS -> DONE; the winner's rdata/err registers load at ACCESS->DONE.
module ram_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        clrn,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_err,
    output logic        cpu_stall,

    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic [31:0] dbg_rdata,
    output logic        dbg_ack,
    output logic        dbg_err,

    output logic        ram_we,
    output logic [4:0]  ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state;
    logic        gnt;        // 0 = CPU, 1 = debug
    logic        last_gnt;   // port served by the most recent grant

    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        bad;
    logic        winner;

    always_comb begin
        sel_we    = gnt ? dbg_we    : cpu_we;
        sel_addr  = gnt ? dbg_addr  : cpu_addr;
        sel_wdata = gnt ? dbg_wdata : cpu_wdata;
        bad       = (sel_addr[31:7] != '0) || (sel_addr[1:0] != 2'b00);

        // A tie goes to the port not served last (round-robin) or to the CPU.
        if (cpu_req && dbg_req) begin
            winner = RR_EN ? ~last_gnt : 1'b0;
        end else begin
            winner = dbg_req;
        end
    end

    // Decoded from the async-reset state so a reset mid-access kills the write at once.
    assign ram_we    = (state == ACCESS) && sel_we && !bad;
    assign ram_addr  = sel_addr[6:2];
    assign ram_wdata = sel_wdata;

    assign cpu_stall = cpu_req & ~cpu_ack;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= IDLE;
            gnt       <= 1'b0;
            last_gnt  <= 1'b1;
            cpu_ack   <= 1'b0;
            dbg_ack   <= 1'b0;
            cpu_err   <= 1'b0;
            dbg_err   <= 1'b0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req || dbg_req) begin
                        gnt      <= winner;
                        last_gnt <= winner;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    state <= DONE;
                    if (gnt) begin
                        dbg_ack <= 1'b1;
                        dbg_err <= bad;
                        if (bad) begin
                            dbg_rdata <= '0;
                        end else if (!sel_we) begin
                            dbg_rdata <= ram_rdata;
                        end
                    end else begin
                        cpu_ack <= 1'b1;
                        cpu_err <= bad;
                        if (bad) begin
                            cpu_rdata <= '0;
                        end else if (!sel_we) begin
                            cpu_rdata <= ram_rdata;
                        end
                    end
                end
                DONE: begin
                    cpu_ack <= 1'b0;
                    dbg_ack <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    cpu_ack <= 1'b0;
                    dbg_ack <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: a round-robin instance with a behavioural RAM model,
// plus a fixed-priority instance exercised with both requests held.
module tb_ram_arbiter;

    logic        clk;
    logic        clrn;

    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic [31:0] cpu_rdata, dbg_rdata;
    logic        cpu_ack, cpu_err, cpu_stall, dbg_ack, dbg_err;
    logic        ram_we;
    logic [4:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;

    logic        f_cpu_req, f_cpu_we, f_dbg_req, f_dbg_we;
    logic [31:0] f_cpu_addr, f_cpu_wdata, f_dbg_addr, f_dbg_wdata;
    logic [31:0] f_cpu_rdata, f_dbg_rdata;
    logic        f_cpu_ack, f_cpu_err, f_cpu_stall, f_dbg_ack, f_dbg_err;
    logic        f_ram_we;
    logic [4:0]  f_ram_addr;
    logic [31:0] f_ram_wdata, f_ram_rdata;

    ram_arbiter #(.RR_EN(1'b1)) dut (
        .clk(clk), .clrn(clrn),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack), .dbg_err(dbg_err),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    ram_arbiter #(.RR_EN(1'b0)) dut_fix (
        .clk(clk), .clrn(clrn),
        .cpu_req(f_cpu_req), .cpu_we(f_cpu_we), .cpu_addr(f_cpu_addr), .cpu_wdata(f_cpu_wdata),
        .cpu_rdata(f_cpu_rdata), .cpu_ack(f_cpu_ack), .cpu_err(f_cpu_err), .cpu_stall(f_cpu_stall),
        .dbg_req(f_dbg_req), .dbg_we(f_dbg_we), .dbg_addr(f_dbg_addr), .dbg_wdata(f_dbg_wdata),
        .dbg_rdata(f_dbg_rdata), .dbg_ack(f_dbg_ack), .dbg_err(f_dbg_err),
        .ram_we(f_ram_we), .ram_addr(f_ram_addr), .ram_wdata(f_ram_wdata), .ram_rdata(f_ram_rdata)
    );

    // Environment RAM for the round-robin instance; the fixed instance reads a pattern ROM.
    logic [31:0] ram_mem [32];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    end
    assign ram_rdata   = ram_mem[ram_addr];
    assign f_ram_rdata = 32'hA5A5_0000 | {27'd0, f_ram_addr};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit          port;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    exp_t        exp_q [$];
    int          total = 0;
    int          nbad  = 0;

    logic [31:0] mdl_mem [32];
    logic [31:0] mdl_rd  [2];
    bit          mdl_last;
    logic [31:0] held_rd  [2];
    logic        held_err [2];
    logic        prev_ack [2];
    bit          mon_en;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            nbad++;
            $display("FAIL %s: got %h want %h", nm, act, exp_v);
        end
    endtask

    task automatic fail(input string nm);
        total++;
        nbad++;
        $display("FAIL %s: got timeout want response", nm);
    endtask

    // Reference: apply one access to the abstract memory and queue the port's expected response.
    task automatic model_apply(input bit p, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                               output bit s_we, output logic [4:0] s_addr);
        exp_t        e;
        bit          b;
        logic [4:0]  idx;
        b   = (addr[31:7] != 0) || (addr[1:0] != 0);
        idx = addr[6:2];
        e.port = p;
        e.err  = b;
        if (b) begin
            e.rdata = 32'd0;
        end else if (we) begin
            mdl_mem[idx] = wd;
            e.rdata = mdl_rd[p];
        end else begin
            e.rdata = mdl_mem[idx];
        end
        mdl_rd[p] = e.rdata;
        mdl_last  = p;
        exp_q.push_back(e);
        s_we   = we && !b;
        s_addr = idx;
    endtask

    // Monitor: pops the scoreboard whenever an ack appears; otherwise outputs must hold.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            chk("cpu_stall", {31'd0, cpu_stall}, {31'd0, cpu_req & ~cpu_ack});
            if (cpu_ack && dbg_ack) chk("both_ack", 32'd1, 32'd0);
            for (int p = 0; p < 2; p++) begin
                logic        a;
                logic [31:0] rd;
                logic        er;
                a  = (p == 1) ? dbg_ack   : cpu_ack;
                rd = (p == 1) ? dbg_rdata : cpu_rdata;
                er = (p == 1) ? dbg_err   : cpu_err;
                if (a) begin
                    chk("ack_pulse", {31'd0, prev_ack[p]}, 32'd0);
                    if (exp_q.size() == 0) begin
                        fail("unexpected_ack");
                    end else begin
                        e = exp_q.pop_front();
                        chk("ack_port", p, {31'd0, e.port});
                        chk("ack_rdata", rd, e.rdata);
                        chk("ack_err", {31'd0, er}, {31'd0, e.err});
                        held_rd[p]  = e.rdata;
                        held_err[p] = e.err;
                        $display("txn %s rdata=%h err=%0d", (p == 1) ? "dbg" : "cpu", rd, er);
                    end
                end else begin
                    chk("hold_rdata", rd, held_rd[p]);
                    chk("hold_err", {31'd0, er}, {31'd0, held_err[p]});
                end
                prev_ack[p] = a;
            end
        end
    end

    // One arbitration round: each going port requests once and drops req in its DONE cycle.
    task automatic do_round(input bit cg, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                            input bit dg, input bit dw, input logic [31:0] da, input logic [31:0] dd,
                            input bit early);
        bit          order  [2];
        bit          s_we   [2];
        logic [4:0]  s_addr [2];
        logic [31:0] s_wd   [2];
        int          nsrv, n, k, cpos, dpos;
        bit          got_c, got_d, drop_c, drop_d;
        if (cg && dg) begin
            order[0] = ~mdl_last;
            order[1] = mdl_last;
            nsrv = 2;
        end else begin
            order[0] = dg;
            order[1] = ~dg;
            nsrv = 1;
        end
        cpos = 0;
        dpos = 0;
        for (int j = 0; j < nsrv; j++) begin
            if (order[j] == 1'b0) begin
                model_apply(1'b0, cw, ca, cd, s_we[j], s_addr[j]);
                s_wd[j] = cd;
                cpos = j;
            end else begin
                model_apply(1'b1, dw, da, dd, s_we[j], s_addr[j]);
                s_wd[j] = dd;
                dpos = j;
            end
        end
        @(negedge clk);
        #2;
        cpu_req = cg; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dbg_req = dg; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
        got_c = !cg;
        got_d = !dg;
        n = 0;
        while (!(got_c && got_d) && n < 12) begin
            @(negedge clk);
            n++;
            k = (n - 1) / 3;
            if (((n - 1) % 3 == 0) && (k < nsrv)) begin
                chk("ram_we_access", {31'd0, ram_we}, {31'd0, s_we[k]});
                chk("ram_addr", {27'd0, ram_addr}, {27'd0, s_addr[k]});
                chk("ram_wdata", ram_wdata, s_wd[k]);
            end else begin
                chk("ram_we_other", {31'd0, ram_we}, 32'd0);
            end
            drop_c = 1'b0;
            drop_d = 1'b0;
            if (cpu_ack && !got_c) begin
                chk("cpu_ack_cycle", n, 2 + 3 * cpos);
                got_c  = 1'b1;
                drop_c = 1'b1;
            end
            if (dbg_ack && !got_d) begin
                chk("dbg_ack_cycle", n, 2 + 3 * dpos);
                got_d  = 1'b1;
                drop_d = 1'b1;
            end
            if (early && n == 1) drop_c = 1'b1;
            #2;
            if (drop_c) cpu_req = 1'b0;
            if (drop_d) dbg_req = 1'b0;
        end
        if (!(got_c && got_d)) begin
            fail("round_timeout");
            cpu_req = 1'b0;
            dbg_req = 1'b0;
        end
    endtask

    function automatic logic [31:0] gen_addr(input bit allow_bad);
        int unsigned r;
        logic [31:0] a;
        r = $urandom_range(0, 9);
        a = {25'd0, 5'($urandom_range(0, 31)), 2'b00};
        if (allow_bad && r == 0) a = a | (32'h80 << $urandom_range(0, 24));
        if (allow_bad && r == 1) a = a | 32'($urandom_range(1, 3));
        return a;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          dummy_we;
        logic [4:0]  dummy_addr;
        bit          order3 [3];
        int          cnt;
        bit          got;

        clrn = 1'b0;
        mon_en = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        f_cpu_req = 0; f_cpu_we = 0; f_cpu_addr = 0; f_cpu_wdata = 0;
        f_dbg_req = 0; f_dbg_we = 0; f_dbg_addr = 0; f_dbg_wdata = 0;
        mdl_last = 1'b1;
        for (int p = 0; p < 2; p++) begin
            mdl_rd[p] = 0; held_rd[p] = 0; held_err[p] = 0; prev_ack[p] = 0;
        end
        for (int i = 0; i < 32; i++) mdl_mem[i] = 32'd0;

        repeat (3) @(negedge clk);
        chk("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
        chk("rst_dbg_ack", {31'd0, dbg_ack}, 32'd0);
        chk("rst_cpu_err", {31'd0, cpu_err}, 32'd0);
        chk("rst_dbg_err", {31'd0, dbg_err}, 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_dbg_rdata", dbg_rdata, 32'd0);
        chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("rst_fix_cpu_ack", {31'd0, f_cpu_ack}, 32'd0);
        #2 clrn = 1'b1;
        mon_en = 1'b1;

        // Write then read 0x50 from the CPU.
        do_round(1, 1, 32'h50, 32'h1234_5678, 0, 0, 0, 0, 0);
        do_round(1, 0, 32'h50, 32'h0, 0, 0, 0, 0, 0);

        // Fill every word, alternating ports.
        for (int i = 0; i < 32; i++) begin
            if (i[0]) do_round(0, 0, 0, 0, 1, 1, 32'(i * 4), $urandom, 0);
            else      do_round(1, 1, 32'(i * 4), $urandom, 0, 0, 0, 0, 0);
        end

        // Bad debug writes, then word 0 must read back unchanged.
        do_round(0, 0, 0, 0, 1, 1, 32'h80, 32'hDEAD_BEEF, 0);
        do_round(0, 0, 0, 0, 1, 1, 32'h06, 32'hDEAD_BEEF, 0);
        do_round(0, 0, 0, 0, 1, 0, 32'h00, 32'h0, 0);

        // Both requests held for three grants.
        for (int j = 0; j < 3; j++) begin
            order3[j] = ~mdl_last;
            if (order3[j]) model_apply(1'b1, 1'b0, 32'h24, 32'h0, dummy_we, dummy_addr);
            else           model_apply(1'b0, 1'b0, 32'h10, 32'h0, dummy_we, dummy_addr);
        end
        @(negedge clk);
        #2;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        dbg_req = 1; dbg_we = 0; dbg_addr = 32'h24;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n % 3 == 2) begin
                chk("held_cpu_ack", {31'd0, cpu_ack}, {31'd0, ~order3[n / 3]});
                chk("held_dbg_ack", {31'd0, dbg_ack}, {31'd0, order3[n / 3]});
            end
        end
        #2;
        cpu_req = 0;
        dbg_req = 0;

        // CPU write whose req drops during ACCESS must still commit.
        do_round(1, 1, gen_addr(0), $urandom, 0, 0, 0, 0, 1);

        // Randomized rounds.
        for (int r = 0; r < 150; r++) begin
            bit cg, dg;
            cg = 1'($urandom_range(0, 1));
            dg = 1'($urandom_range(0, 1));
            if (!cg && !dg) cg = 1'b1;
            do_round(cg, 1'($urandom_range(0, 1)), gen_addr(1), $urandom,
                     dg, 1'($urandom_range(0, 1)), gen_addr(1), $urandom, 0);
        end

        // Fixed-priority instance: debug must never win while the CPU keeps requesting.
        @(negedge clk);
        #2;
        f_cpu_req = 1; f_cpu_we = 0; f_cpu_addr = 32'h10; f_cpu_wdata = 32'hCAFE_0001;
        f_dbg_req = 1; f_dbg_we = 0; f_dbg_addr = 32'h24; f_dbg_wdata = 32'hCAFE_0002;
        cnt = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            chk("fix_dbg_ack", {31'd0, f_dbg_ack}, 32'd0);
            chk("fix_ram_we", {31'd0, f_ram_we}, 32'd0);
            if (n % 3 == 1) chk("fix_ram_wdata", f_ram_wdata, 32'hCAFE_0001);
            if (f_cpu_ack) cnt++;
        end
        chk("fix_cpu_acks", cnt, 4);
        chk("fix_cpu_rdata", f_cpu_rdata, 32'hA5A5_0004);
        chk("fix_cpu_err", {31'd0, f_cpu_err}, 32'd0);
        #2 f_cpu_req = 0;
        got = 1'b0;
        for (int n = 0; n < 6 && !got; n++) begin
            @(negedge clk);
            if (f_dbg_ack) got = 1'b1;
        end
        chk("fix_dbg_served", {31'd0, got}, 32'd1);
        chk("fix_dbg_rdata", f_dbg_rdata, 32'hA5A5_0009);
        #2 f_dbg_req = 0;

        // Reset during a write ACCESS.
        @(negedge clk);
        #2;
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h0C; cpu_wdata = ~mdl_mem[3];
        @(negedge clk);
        chk("rst_mid_pre_we", {31'd0, ram_we}, 32'd1);
        #2 clrn = 1'b0;
        #1;
        chk("rst_mid_ram_we", {31'd0, ram_we}, 32'd0);
        chk("rst_mid_cpu_ack", {31'd0, cpu_ack}, 32'd0);
        chk("rst_mid_dbg_ack", {31'd0, dbg_ack}, 32'd0);
        chk("rst_mid_cpu_err", {31'd0, cpu_err}, 32'd0);
        chk("rst_mid_dbg_err", {31'd0, dbg_err}, 32'd0);
        chk("rst_mid_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_mid_dbg_rdata", dbg_rdata, 32'd0);
        cpu_req = 0;
        mdl_last = 1'b1;
        for (int p = 0; p < 2; p++) begin
            mdl_rd[p] = 0; held_rd[p] = 0; held_err[p] = 0;
        end
        repeat (2) @(negedge clk);
        chk("rst_mid_word", ram_mem[3], mdl_mem[3]);
        #2 clrn = 1'b1;

        // First tie after reset goes to the CPU.
        do_round(1, 0, 32'h0C, 0, 1, 0, 32'h14, 0, 0);
        do_round(1, 0, 32'h50, 0, 0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        chk("exp_q_empty", exp_q.size(), 0);
        for (int i = 0; i < 32; i++) chk("ram_final", ram_mem[i], mdl_mem[i]);

        $display("test done: total=%0d bad=%0d", total, nbad);
        $finish;
    end

endmodule
